// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 2^N_IN input vectors into a combinational DUT and checks dut_f against EXP_TT
//   clk, rst (sync, active-high) | start: begin a sweep (ignored while busy) | dut_f: DUT output
//   vec_out: DUT stimulus (MSB = x1) | busy, done, pass | err_count (N_IN+1 bits) | first_fail, first_fail_valid
//   Build option: SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatch and holds vec_out at the failing vector.
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int SETTLE = 5,
  parameter logic [2**N_IN-1:0] EXP_TT = 16'h6996
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);
  localparam int HW = SETTLE > 1 ? $clog2(SETTLE) : 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [HW-1:0] hold;
  logic accept, sample, miss, last, stop;
  assign accept = start && state != RUN;
  assign sample = state == RUN && hold == HW'(SETTLE - 1);
  assign miss = sample && (dut_f != EXP_TT[vec_out]);
  assign last = vec_out == '1;
  assign stop = STOP && miss;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? RUN : (sample && (last || stop)) ? FIN : state;
  always_comb begin
    busy = state == RUN;
    done = state == FIN;
  end
  always_ff @(posedge clk)
    if (rst || accept) begin
      vec_out <= '0;
      hold <= '0;
      err_count <= '0;
      first_fail <= '0;
      first_fail_valid <= 1'b0;
      pass <= 1'b0;
    end else if (sample) begin
      err_count <= err_count + (N_IN + 1)'(miss);
      if (miss && !first_fail_valid) begin
        first_fail <= vec_out;
        first_fail_valid <= 1'b1;
      end
      hold <= '0;
      // incrementing past the last vector wraps vec_out back to 0
      if (!stop) vec_out <= vec_out + 1'b1;
      // include this edge's miss, since err_count has not yet absorbed it
      if (last && !stop) pass <= err_count == '0 && !miss;
    end else if (state == RUN) hold <= hold + 1'b1;
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking stimulus engine for combinational DUTs.
- On `start`, drives all 2^N_IN input vectors in ascending binary order and holds each for SETTLE cycles.
- Samples the DUT output on the last hold cycle of each vector and compares it against a parameterised expected truth table.
- Reports the mismatch count and the first failing vector. Replaces hand-written per-vector stimulus sequences in the lab benches.

Parameters:
- N_IN, 4: number of DUT inputs; sweep length is 2^N_IN vectors.
- SETTLE, 5: hold cycles per vector, >=1; DUT output is sampled on the final hold cycle.
- EXP_TT, 16'h6996: expected truth table, width 2^N_IN. Bit i is the expected output for input vector i. Default is 4-input odd parity.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep
- dut_f  input  1  DUT output under test
- vec_out  output  N_IN  stimulus to DUT; vec_out[N_IN-1] maps to x1 (MSB)
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep end until the next accepted start or rst
- pass  output  1  valid when done=1; 1 if err_count==0
- err_count  output  N_IN+1  number of mismatching vectors, range 0..2^N_IN
- first_fail  output  N_IN  index of the first mismatching vector
- first_fail_valid  output  1  high once any mismatch has been recorded

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE.
- FSM states:
  - IDLE: busy=0, vec_out=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Start acceptance:
  - start is accepted in IDLE or DONE only.
  - On acceptance: clear err_count, first_fail, first_fail_valid, done and pass; set vec_out=0 and the hold counter to 0; enter RUN.
  - start while busy=1 is ignored.
- RUN timing:
  - If start is accepted at edge k, vector i is driven in cycles k+i*SETTLE+1 through k+(i+1)*SETTLE.
  - dut_f is sampled at edge k+(i+1)*SETTLE.
  - On a mismatch (dut_f != EXP_TT[i]): err_count increments. If first_fail_valid=0, first_fail<=i and first_fail_valid<=1.
  - After sampling vector i < 2^N_IN-1: vec_out<=i+1 and the hold counter reloads.
- Wrap-around: after sampling vector 2^N_IN-1, vec_out wraps to 0 and the FSM enters DONE. done=1 and pass=(final err_count==0) are visible from edge k+2^N_IN*SETTLE. Total sweep length is 2^N_IN*SETTLE cycles.
- Width rules:
  - err_count is N_IN+1 bits and never saturates: an all-fail sweep reads exactly 2^N_IN.
  - pass must account for a mismatch on the final vector (same-edge update).
- DONE: outputs hold until the next accepted start or rst. vec_out=0.
- rst mid-sweep: at the next edge the FSM returns to IDLE and every output takes its reset value; no partial result is retained.
- rst and start in the same cycle: rst wins; start is dropped.
- dut_f is not sampled outside RUN; X on dut_f in IDLE/DONE has no effect.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined:
  - On the first mismatch the FSM enters DONE at that sample edge, with pass=0 and err_count=1.
  - vec_out holds the failing vector (equal to first_fail) in DONE, for waveform debug.
- Undefined: the full sweep always runs and vec_out returns to 0 in DONE.

Test Plan:
- Defaults (N_IN=4, SETTLE=5), DUT model = 4-input XOR, start at cycle 2 -> vec_out steps 0..15 every 5 cycles; done=1 at cycle 82; pass=1, err_count=0, first_fail_valid=0.
- XOR model with output inverted for vector 5 only -> err_count=1, first_fail=5, first_fail_valid=1, pass=0.
- dut_f tied 0 against EXP_TT=16'h6996 -> err_count=8, first_fail=1. With dut_f tied to the inverted XOR (all vectors fail) -> err_count=16 (5'b10000).
- start pulsed again while vec_out=7 -> ignored; sweep completes at the original time. A start after done -> counters clear and a fresh sweep runs.
- rst asserted while vec_out=9 -> next edge: busy=0, vec_out=0, err_count=0, done=0. A subsequent start gives a normal full sweep.
- N_IN=2, SETTLE=1, EXP_TT=4'b1000 (AND), AND model -> vec_out 0,1,2,3 on consecutive cycles; done one cycle after the last sample; pass=1.
- With SWEEP_STOP_ON_FAIL_EN and a fault at vector 5 -> done at sample edge of vector 5; vec_out=5, err_count=1; busy=0.
